mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 16-bit pipelined processor. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Drives a request/acknowledge data-memory port and stalls the pipeline until the access completes. Resolves the branch decision and feeds the MEM/WB register with the load data, ALU result and WB controls.
- Non-memory instructions pass through in one cycle.

Parameters:
DATA_W, 16, data and address width
REG_ADDR_W, 4, destination register index width
TIMEOUT, 15, max cycles mem_req waits for mem_ack before abort (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
branch4  in  1  branch instruction flag from EX/MEM
aluZero4  in  1  ALU zero flag from EX/MEM
branchTarget4  in  DATA_W  branch target address from EX/MEM
aluResult4  in  DATA_W  ALU result / memory address
writeData4  in  DATA_W  store data
destReg4  in  REG_ADDR_W  destination register index
memRead4, memWrite4, regWrite4, memtoReg4  in  1 each  control flags
pcSrc  out  1  take branch (combinational)
pcBranch  out  DATA_W  equals branchTarget4 (combinational)
stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM (combinational)
mem_req, mem_we  out  1  memory request / write enable
mem_addr, mem_wdata  out  DATA_W  latched address / store data
mem_ack  in  1  memory completion, valid only while mem_req=1
mem_rdata  in  DATA_W  load data, valid with mem_ack
memErr  out  1  sticky timeout flag
readData5, aluResult5  out  DATA_W  MEM/WB data
destReg5  out  REG_ADDR_W  MEM/WB destination register
regWrite5, memtoReg5  out  1  MEM/WB controls

Behaviour:
- Reset, at the clock edge with rst=1:
  - All registered outputs and the counter go to 0; state goes to IDLE; memErr goes to 0.
  - rst wins over every other event, including mid-ACCESS: mem_req is 0 from the next cycle and no WB write is produced.
- access = memRead4 | memWrite4. If both are set, the access is a write (mem_we=1).
- IDLE state:
  - access=0: at the edge, the MEM/WB register loads aluResult4, destReg4, regWrite4 and memtoReg4; readData5 holds. Latency is 1 cycle.
  - access=1: stall=1 combinationally. At the edge, latch mem_addr=aluResult4, mem_wdata=writeData4 and mem_we; go to ACCESS; clear the counter; MEM/WB loads a bubble (regWrite5=0, memtoReg5=0).
- ACCESS state:
  - mem_req=1. mem_addr, mem_wdata and mem_we are held stable.
  - mem_ack=1:
    - stall=0 in that same cycle, so upstream advances at that edge.
    - At the edge, MEM/WB loads readData5=mem_rdata (loads only; stores leave it unchanged) plus aluResult4, destReg4, regWrite4 and memtoReg4.
    - Go to IDLE; mem_req=0 the next cycle.
    - Minimum load/store latency is 2 cycles.
  - mem_ack=0 with counter < TIMEOUT-1: stall=1, counter increments, MEM/WB holds a bubble.
  - mem_ack=0 with counter = TIMEOUT-1: this is the timeout.
    - stall=0 that cycle; at the edge memErr goes to 1 and go to IDLE.
    - MEM/WB gets regWrite5=0 (instruction squashed).
    - The counter does not wrap.
- mem_ack while mem_req=0 is ignored.
- Back-to-back accesses: after an ack the state returns to IDLE. The next access is seen the following cycle and needs a fresh IDLE->ACCESS transition. No overlap is allowed.
- pcSrc = branch4 & aluZero4, independent of stall. Branches never access memory.
- memErr is cleared only by rst.

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum: IDLE, ACCESS;
  - DATA_W and REG_ADDR_W defaults;
  - the TIMEOUT counter width (4 bits).
- One natural sub-module, register4: the MEM/WB pipeline register with synchronous reset and a bubble input. The stage's FSM, counter and address latch instantiate it.

Test Plan:
1. ALU op: aluResult4=0x1234, destReg4=3, regWrite4=1, no memory flags -> next edge aluResult5=0x1234, destReg5=3, regWrite5=1; stall=0 throughout; mem_req=0.
2. Load: memRead4=1, aluResult4=0x0040, ack asserted 3 cycles after mem_req with mem_rdata=0xBEEF -> stall=1 for 4 cycles, mem_addr=0x0040, then readData5=0xBEEF, memtoReg5=1, regWrite5=1; bubbles before that.
3. Store with immediate ack: memWrite4=1, aluResult4=0x0010, writeData4=0x00AA, ack in the first ACCESS cycle -> mem_we=1, mem_wdata=0x00AA, stall high exactly 1 cycle, regWrite5=0.
4. Timeout: load with mem_ack never asserted -> mem_req high exactly 15 cycles; then memErr=1, stall=0, regWrite5=0, state IDLE; memErr stays 1 until rst.
5. Reset mid-access: rst pulsed in the 2nd ACCESS cycle -> next cycle mem_req=0, stall=0, all MEM/WB outputs 0, memErr=0.
6. Branch: branch4=1, aluZero4=1, branchTarget4=0x0100 -> pcSrc=1, pcBranch=0x0100 in the same cycle. With aluZero4=0 -> pcSrc=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM stage of the 16-bit pipeline.
package mem_stage_pkg;
  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int CNT_W          = 4;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
endpackage

// File: rtl/register4.sv
// MEM/WB pipeline register: bubble clears the WB controls and holds the data fields.
module register4
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic                  load_rd,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  reg_write,
  input  logic                  memto_reg,
  output logic [DATA_W-1:0]     read_data_q,
  output logic [DATA_W-1:0]     alu_result_q,
  output logic [REG_ADDR_W-1:0] dest_reg_q,
  output logic                  reg_write_q,
  output logic                  memto_reg_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      dest_reg_q   <= '0;
      reg_write_q  <= 1'b0;
      memto_reg_q  <= 1'b0;
    end else if (bubble) begin
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
    end else begin
      alu_result_q <= alu_result;
      dest_reg_q   <= dest_reg;
      reg_write_q  <= reg_write;
      memto_reg_q  <= memto_reg;
      // stores and ALU ops leave the last load value in place
      if (load_rd) read_data_q <= rdata;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data port with timeout, branch resolve, MEM/WB feed.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch4,
  input  logic                  aluZero4,
  input  logic [DATA_W-1:0]     branchTarget4,
  input  logic [DATA_W-1:0]     aluResult4,
  input  logic [DATA_W-1:0]     writeData4,
  input  logic [REG_ADDR_W-1:0] destReg4,
  input  logic                  memRead4,
  input  logic                  memWrite4,
  input  logic                  regWrite4,
  input  logic                  memtoReg4,
  output logic                  pcSrc,
  output logic [DATA_W-1:0]     pcBranch,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  memErr,
  output logic [DATA_W-1:0]     readData5,
  output logic [DATA_W-1:0]     aluResult5,
  output logic [REG_ADDR_W-1:0] destReg5,
  output logic                  regWrite5,
  output logic                  memtoReg5
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             access, timeout, bubble, load_rd;

  assign access   = memRead4 | memWrite4;
  assign pcSrc    = branch4 & aluZero4;
  assign pcBranch = branchTarget4;
  assign mem_req  = (state == ACCESS);
  assign timeout  = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

  // Stall drops in the ack or timeout cycle so upstream advances on that same edge.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = access;
      ACCESS:  stall = !mem_ack && !timeout;
      default: stall = 1'b0;
    endcase
  end

  // In ACCESS, anything but an ack (waiting or timed out) leaves a bubble in MEM/WB.
  assign bubble  = (state == IDLE) ? access : !mem_ack;
  assign load_rd = (state == ACCESS) && mem_ack && !mem_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      memErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (access) begin
          mem_addr  <= aluResult4;
          mem_wdata <= writeData4;
          mem_we    <= memWrite4;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (mem_ack) begin
            state <= IDLE;
          end else if (timeout) begin
            memErr <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  register4 #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_memwb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (bubble),
    .load_rd      (load_rd),
    .rdata        (mem_rdata),
    .alu_result   (aluResult4),
    .dest_reg     (destReg4),
    .reg_write    (regWrite4),
    .memto_reg    (memtoReg4),
    .read_data_q  (readData5),
    .alu_result_q (aluResult5),
    .dest_reg_q   (destReg5),
    .reg_write_q  (regWrite5),
    .memto_reg_q  (memtoReg5)
  );
endmodule
